mac_csa_unit: RTL and testbench



---
 rtl/mac_pkg.sv | 19 +
 rtl/mac_csa_unit_if.sv | 23 ++
 rtl/csa_3to2.sv | 16 +
 rtl/mac_csa_unit.sv | 118 +++++++++++
 tb/tb_mac_csa_unit.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the carry-save multiply-accumulate unit:
// default widths, FSM encoding and a counter-width helper.
package mac_pkg;

   localparam int unsigned DEF_INPUT_LENGTH  = 16;
   localparam int unsigned DEF_OUTPUT_LENGTH = 32;
   localparam int unsigned DEF_CHUNK_WIDTH   = 8;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] MUL     = 2'd1;
   localparam logic [1:0] RET_ADD = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   // A counter over n steps still needs at least one bit when n == 1.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mac_csa_unit_if.sv
// Command/result bundle between the UART front-end (master) and the MAC unit (slave).
interface mac_csa_unit_if #(
   parameter int unsigned INPUT_LENGTH  = mac_pkg::DEF_INPUT_LENGTH,
   parameter int unsigned OUTPUT_LENGTH = mac_pkg::DEF_OUTPUT_LENGTH
);
   logic [INPUT_LENGTH-1:0]  iA;
   logic [INPUT_LENGTH-1:0]  iB;
   logic                     iMAC;
   logic                     iRET;
   logic [OUTPUT_LENGTH-1:0] oRes;
   logic                     oReady;
   logic                     oDone;

   modport master (
      output iA, iB, iMAC, iRET,
      input  oRes, oReady, oDone
   );

   modport slave (
      input  iA, iB, iMAC, iRET,
      output oRes, oReady, oDone
   );
endinterface

// File: rtl/csa_3to2.sv
// Combinational 3:2 carry-save compressor; the carry vector is returned
// already shifted into its weight and truncated to WIDTH.
module csa_3to2 #(
   parameter int unsigned WIDTH = mac_pkg::DEF_OUTPUT_LENGTH
) (
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   input  logic [WIDTH-1:0] i_z,
   output logic [WIDTH-1:0] o_sum,
   output logic [WIDTH-1:0] o_carry
);

   assign o_sum   = i_x ^ i_y ^ i_z;
   assign o_carry = ((i_x & i_y) | (i_x & i_z) | (i_y & i_z)) << 1;

endmodule

// File: rtl/mac_csa_unit.sv
// Iterative shift-and-add multiplier feeding a carry-save accumulator, resolved
// to binary on RET by a chunked ripple adder that is LSB-chunk first.
module mac_csa_unit
   import mac_pkg::*;
#(
   parameter int unsigned INPUT_LENGTH  = DEF_INPUT_LENGTH,
   parameter int unsigned OUTPUT_LENGTH = DEF_OUTPUT_LENGTH,
   parameter int unsigned CHUNK_WIDTH   = DEF_CHUNK_WIDTH
) (
   input logic          iClk,
   input logic          iRst,
   mac_csa_unit_if.slave bus
);

   localparam int unsigned N_CHUNKS = OUTPUT_LENGTH / CHUNK_WIDTH;
   localparam int unsigned BIT_W    = cnt_width(INPUT_LENGTH);
   localparam int unsigned CHUNK_W  = cnt_width(N_CHUNKS);

   logic [1:0]               r_state;
   logic [OUTPUT_LENGTH-1:0] r_S;
   logic [OUTPUT_LENGTH-1:0] r_C;
   logic [INPUT_LENGTH-1:0]  r_A;
   logic [INPUT_LENGTH-1:0]  r_B;
   logic [BIT_W-1:0]         r_bit;
   logic [CHUNK_W-1:0]       r_chunk;
   logic                     r_carry;
   logic [OUTPUT_LENGTH-1:0] r_shadow;
   logic [OUTPUT_LENGTH-1:0] r_res;

   logic [OUTPUT_LENGTH-1:0] w_pp;
   logic [OUTPUT_LENGTH-1:0] w_csa_sum;
   logic [OUTPUT_LENGTH-1:0] w_csa_carry;
   logic [CHUNK_WIDTH:0]     w_chunk_sum;
   logic [OUTPUT_LENGTH-1:0] w_shadow_next;
   logic                     w_last_bit;
   logic                     w_last_chunk;

   assign w_pp = r_B[r_bit] ? (OUTPUT_LENGTH'(r_A) << r_bit) : '0;

   csa_3to2 #(
      .WIDTH (OUTPUT_LENGTH)
   ) u_csa (
      .i_x     (r_S),
      .i_y     (r_C),
      .i_z     (w_pp),
      .o_sum   (w_csa_sum),
      .o_carry (w_csa_carry)
   );

   always_comb begin
      w_chunk_sum   = {1'b0, r_S[r_chunk*CHUNK_WIDTH +: CHUNK_WIDTH]}
                    + {1'b0, r_C[r_chunk*CHUNK_WIDTH +: CHUNK_WIDTH]}
                    + {{CHUNK_WIDTH{1'b0}}, r_carry};
      w_shadow_next = r_shadow;
      w_shadow_next[r_chunk*CHUNK_WIDTH +: CHUNK_WIDTH] = w_chunk_sum[CHUNK_WIDTH-1:0];
   end

   assign w_last_bit   = (r_bit == BIT_W'(INPUT_LENGTH - 1));
   assign w_last_chunk = (r_chunk == CHUNK_W'(N_CHUNKS - 1));

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_state  <= IDLE;
         r_S      <= '0;
         r_C      <= '0;
         r_A      <= '0;
         r_B      <= '0;
         r_bit    <= '0;
         r_chunk  <= '0;
         r_carry  <= 1'b0;
         r_shadow <= '0;
         r_res    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.iMAC) begin
                  r_A     <= bus.iA;
                  r_B     <= bus.iB;
                  r_bit   <= '0;
                  r_state <= MUL;
               end else if (bus.iRET) begin
                  r_chunk <= '0;
                  r_carry <= 1'b0;
                  r_state <= RET_ADD;
               end
            end
            MUL: begin
               r_S <= w_csa_sum;
               r_C <= w_csa_carry;
               if (w_last_bit) r_state <= IDLE;
               else            r_bit   <= r_bit + 1'b1;
            end
            RET_ADD: begin
               r_shadow <= w_shadow_next;
               r_carry  <= w_chunk_sum[CHUNK_WIDTH];
               // Publishing on the final chunk edge makes oRes valid in the DONE cycle itself.
               if (w_last_chunk) begin
                  r_res   <= w_shadow_next;
                  r_state <= DONE;
               end else begin
                  r_chunk <= r_chunk + 1'b1;
               end
            end
            DONE: begin
               r_S     <= '0;
               r_C     <= '0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.oRes   = r_res;
   assign bus.oReady = (r_state == IDLE);
   assign bus.oDone  = (r_state == DONE);

endmodule

// File: tb/tb_mac_csa_unit.sv
// Directed bench for mac_csa_unit: RET commands push expected results into a
// scoreboard queue that an independent monitor drains on every oDone pulse.
module tb_mac_csa_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mac_csa_unit_if bus ();

   mac_csa_unit dut (
      .iClk (clk),
      .iRst (rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic timeout(input string name);
      n_total++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (!rst && bus.oDone) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_done: got oDone with oRes=0x%08h, expected no pulse", bus.oRes);
         end else begin
            check("ret_result", bus.oRes, exp_q.pop_front());
         end
      end
   end

   task automatic wait_ready();
      for (int c = 0; c < 60; c++) begin
         if (bus.oReady) return;
         @(negedge clk);
      end
      timeout("wait_ready");
   endtask

   // One MAC; optionally a stray iMAC at busy cycle `inject`, optionally iRET alongside.
   task automatic do_mac(input logic [15:0] a, input logic [15:0] b,
                         input int inject, input bit also_ret);
      int lo;
      bit up;
      wait_ready();
      bus.iA = a; bus.iB = b; bus.iMAC = 1'b1; bus.iRET = also_ret;
      @(posedge clk); #1;
      bus.iMAC = 1'b0; bus.iRET = 1'b0; bus.iA = 16'hDEAD; bus.iB = 16'hBEEF;
      lo = 0; up = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         bus.iMAC = (c == inject);
         if (c == inject) begin bus.iA = 16'h00FF; bus.iB = 16'h00FF; end
         if (bus.oReady) begin up = 1'b1; break; end
         lo++;
      end
      bus.iMAC = 1'b0;
      if (!up) timeout("mac_ready_return");
      check("mac_busy_cycles", 32'(lo), 32'd16);
   endtask

   // One RET with expected result; optionally a stray iRET at busy cycle `inject`.
   task automatic do_ret(input logic [31:0] exp, input int inject);
      int done_at;
      int ready_at;
      wait_ready();
      exp_q.push_back(exp);
      bus.iRET = 1'b1;
      @(posedge clk); #1;
      bus.iRET = 1'b0;
      done_at = 0; ready_at = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         bus.iRET = (c == inject);
         if (bus.oDone && done_at == 0) done_at = c;
         if (bus.oReady) begin ready_at = c; break; end
      end
      bus.iRET = 1'b0;
      if (ready_at == 0) timeout("ret_ready_return");
      check("ret_done_latency", 32'(done_at), 32'd5);
      check("ret_ready_latency", 32'(ready_at), 32'd6);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.iA = '0; bus.iB = '0; bus.iMAC = 1'b0; bus.iRET = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_ready", 32'(bus.oReady), 32'd1);
      check("reset_done", 32'(bus.oDone), 32'd0);
      check("reset_res", bus.oRes, 32'h0);

      // 3*5 + 7*11 = 92
      do_mac(16'd3, 16'd5, 0, 1'b0);
      do_mac(16'd7, 16'd11, 0, 1'b0);
      do_ret(32'h0000005C, 0);

      do_mac(16'hFFFF, 16'hFFFF, 0, 1'b0);
      do_ret(32'hFFFE0001, 0);
      do_ret(32'h00000000, 0);

      // 2 * 0xFFFE0001 wraps to 0xFFFC0002
      do_mac(16'hFFFF, 16'hFFFF, 0, 1'b0);
      do_mac(16'hFFFF, 16'hFFFF, 0, 1'b0);
      do_ret(32'hFFFC0002, 0);

      // Stray commands while busy are dropped: 3*4 = 12
      do_mac(16'd3, 16'd4, 5, 1'b0);
      do_ret(32'h0000000C, 2);

      // Simultaneous iMAC/iRET: MAC wins, no result pulse
      do_mac(16'd2, 16'd2, 0, 1'b1);
      do_ret(32'h00000004, 0);

      // Reset mid-MUL discards the operation and clears oRes
      wait_ready();
      bus.iA = 16'h1234; bus.iB = 16'h5678; bus.iMAC = 1'b1;
      @(posedge clk); #1;
      bus.iMAC = 1'b0;
      repeat (7) @(negedge clk);
      check("mul_busy_before_reset", 32'(bus.oReady), 32'd0);
      check("res_before_reset", bus.oRes, 32'h00000004);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 32'(bus.oReady), 32'd1);
      check("res_after_reset", bus.oRes, 32'h0);
      check("done_after_reset", 32'(bus.oDone), 32'd0);
      do_ret(32'h00000000, 0);

      repeat (20) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
